// File: rtl/dmem_responder_if.sv
// CPU-side data memory bus for dmem_responder: request, direction, size, address,
// store data, registered load data, stall and sticky misalignment flag.
interface dmem_responder_if;
    logic        dmem_ena;
    logic        dmem_wena;
    logic [1:0]  d_ram_instr;
    logic [12:0] dmem_addr;
    logic [31:0] dmem_in;
    logic [31:0] dmem_out;
    logic        dmem_stall;
    logic        dmem_err;

    modport master (
        output dmem_ena, dmem_wena, d_ram_instr, dmem_addr, dmem_in,
        input  dmem_out, dmem_stall, dmem_err
    );

    modport slave (
        input  dmem_ena, dmem_wena, d_ram_instr, dmem_addr, dmem_in,
        output dmem_out, dmem_stall, dmem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// 2048x32 data memory responder: single-cycle word stores, two-cycle loads and
// read-modify-write sub-word stores. Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned accesses.
module dmem_responder (
    input  logic              clk_in,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, MERGE} state_t;

    state_t      state_q;
    logic [31:0] mem_q [2048];
    logic [12:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] dout_q;

    logic is_half, is_byte, is_word, misaligned;
    logic idle_req, do_load, do_sub_store, do_word_store;

    // Size 11 behaves as a word access.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b01:   return {16'h0, (lo[1] ? word[31:16] : word[15:0])};
            2'b10:   return {24'h0, sh[7:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo);
        logic [31:0] mask;
        case (size)
            2'b01:   return lo[1] ? {data[15:0], old[15:0]} : {old[31:16], data[15:0]};
            2'b10: begin
                mask = 32'h0000_00FF << {lo, 3'b000};
                return (old & ~mask) | ((data & 32'h0000_00FF) << {lo, 3'b000});
            end
            default: return data;
        endcase
    endfunction

    always_comb begin
        is_half = (bus.d_ram_instr == 2'b01);
        is_byte = (bus.d_ram_instr == 2'b10);
        is_word = !is_half && !is_byte;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = (is_word && (bus.dmem_addr[1:0] != 2'b00)) || (is_half && bus.dmem_addr[0]);
`else
        misaligned = 1'b0;
`endif
        idle_req      = (state_q == IDLE) && bus.dmem_ena;
        do_load       = idle_req && !misaligned && !bus.dmem_wena;
        do_sub_store  = idle_req && !misaligned && bus.dmem_wena && !is_word;
        do_word_store = idle_req && !misaligned && bus.dmem_wena && is_word;
    end

    assign bus.dmem_stall = do_load || do_sub_store;
    assign bus.dmem_out   = dout_q;

    // Storage and captured request are never reset; reset only blocks writes.
    always_ff @(posedge clk_in) begin
        if (!reset && do_word_store) begin
            mem_q[bus.dmem_addr[12:2]] <= bus.dmem_in;
        end else if (!reset && state_q == MERGE) begin
            mem_q[addr_q[12:2]] <= lane_merge(rdata_q, wdata_q, size_q, addr_q[1:0]);
        end
        if (do_load || do_sub_store) begin
            addr_q  <= bus.dmem_addr;
            size_q  <= bus.d_ram_instr;
            wdata_q <= bus.dmem_in;
            rdata_q <= mem_q[bus.dmem_addr[12:2]];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            dout_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (do_load) begin
                        state_q <= READ;
                    end else if (do_sub_store) begin
                        state_q <= MERGE;
                    end
                end
                READ: begin
                    dout_q  <= lane_extract(rdata_q, size_q, addr_q[1:0]);
                    state_q <= IDLE;
                end
                MERGE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    // Sticky until reset: set by any trapped request taken in IDLE.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (idle_req && misaligned) begin
            err_q <= 1'b1;
        end
    end

    assign bus.dmem_err = err_q;
`else
    assign bus.dmem_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a byte-lane memory model.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    localparam bit TRAP =
`ifdef DMEM_MISALIGN_TRAP_EN
        1'b1;
`else
        1'b0;
`endif

    logic [31:0] ref_mem [2048];
    logic [31:0] ref_out;
    logic        ref_err;

    dmem_responder_if bus ();

    dmem_responder dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit with_store_req);
        rst = 1'b1;
        bus.dmem_ena    = with_store_req;
        bus.dmem_wena   = 1'b1;
        bus.d_ram_instr = 2'b00;
        bus.dmem_addr   = 13'h030;
        bus.dmem_in     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.dmem_ena = 1'b0;
        rst = 1'b0;
        ref_out = 32'h0;
        ref_err = 1'b0;
    endtask

    // Issues one CPU request, holding it while stall is high, and scores the result.
    task automatic access(input string tag, input bit we, input logic [1:0] sz,
                          input logic [12:0] a, input logic [31:0] d);
        int          n, exp_n, nbytes, off;
        bit          half, byt, word, mis;
        logic [31:0] w;
        half = (sz == 2'b01);
        byt  = (sz == 2'b10);
        word = !half && !byt;
        mis  = TRAP && ((word && a[1:0] != 2'b00) || (half && a[0]));
        nbytes = word ? 4 : (half ? 2 : 1);
        off    = word ? 0 : (half ? 2 * int'(a[1]) : int'(a[1:0]));
        w = ref_mem[a[12:2]];
        if (mis) begin
            exp_n   = 0;
            ref_err = 1'b1;
        end else if (!we) begin
            exp_n   = 1;
            ref_out = 32'h0;
            for (int i = 0; i < nbytes; i++) ref_out[8*i +: 8] = w[8*(off+i) +: 8];
        end else begin
            exp_n = word ? 0 : 1;
            for (int i = 0; i < nbytes; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
            ref_mem[a[12:2]] = w;
        end

        bus.dmem_ena    = 1'b1;
        bus.dmem_wena   = we;
        bus.d_ram_instr = sz;
        bus.dmem_addr   = a;
        bus.dmem_in     = d;
        #1;
        n = 0;
        while (bus.dmem_stall === 1'b1 && n < 5) begin
            @(posedge clk);
            #2;
            n++;
        end
        // Captured values must be used once the request has been accepted.
        if (n > 0) begin
            bus.dmem_wena   = 1'($urandom);
            bus.d_ram_instr = 2'($urandom);
            bus.dmem_addr   = 13'($urandom);
            bus.dmem_in     = $urandom;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
        @(posedge clk);
        #1;
        bus.dmem_ena = 1'b0;
        check({tag, "_out"}, bus.dmem_out, ref_out);
        check({tag, "_err"}, 32'(bus.dmem_err), 32'(ref_err));
    endtask

    task automatic idle(input string tag, input int k);
        bus.dmem_ena = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        check({tag, "_stall"}, 32'(bus.dmem_stall), 32'h0);
        check({tag, "_out"}, bus.dmem_out, ref_out);
        check({tag, "_err"}, 32'(bus.dmem_err), 32'(ref_err));
    endtask

    initial begin
        logic [12:0] a;
        int          r;
        rst = 1'b1;
        bus.dmem_ena = 1'b0;
        bus.dmem_wena = 1'b0;
        bus.d_ram_instr = 2'b00;
        bus.dmem_addr = 13'h0;
        bus.dmem_in = 32'h0;
        ref_out = 32'h0;
        ref_err = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        idle("reset_idle", 3);

        access("st_deadbeef", 1'b1, 2'b00, 13'h010, 32'hDEAD_BEEF);
        access("ld_deadbeef", 1'b0, 2'b00, 13'h010, 32'h0);
        check("ld_deadbeef_const", bus.dmem_out, 32'hDEAD_BEEF);
        idle("hold_after_load", 3);

        access("st_byte55", 1'b1, 2'b10, 13'h012, 32'h0000_0055);
        access("st_halfa5", 1'b1, 2'b01, 13'h010, 32'h0000_A5A5);
        access("ld_merged", 1'b0, 2'b00, 13'h010, 32'h0);
        check("ld_merged_const", bus.dmem_out, 32'hDE55_A5A5);
        access("ld_byte13", 1'b0, 2'b10, 13'h013, 32'h0);
        check("ld_byte13_const", bus.dmem_out, 32'h0000_00DE);

        // Reset in MERGE aborts the sub-word write.
        access("st_orig20", 1'b1, 2'b00, 13'h020, 32'h1122_3344);
        bus.dmem_ena = 1'b1; bus.dmem_wena = 1'b1; bus.d_ram_instr = 2'b10;
        bus.dmem_addr = 13'h021; bus.dmem_in = 32'h0000_0099;
        #1;
        check("merge_rst_stall", 32'(bus.dmem_stall), 32'h1);
        @(posedge clk);
        #1;
        do_reset(1'b0);
        access("ld_after_merge_rst", 1'b0, 2'b00, 13'h020, 32'h0);
        check("ld_after_merge_rst_const", bus.dmem_out, 32'h1122_3344);

        // Reset in READ leaves dmem_out at zero.
        bus.dmem_ena = 1'b1; bus.dmem_wena = 1'b0; bus.d_ram_instr = 2'b00;
        bus.dmem_addr = 13'h010;
        @(posedge clk);
        #1;
        do_reset(1'b0);
        check("read_rst_out", bus.dmem_out, 32'h0);

        // Reset wins over a simultaneous word store.
        access("st_30", 1'b1, 2'b00, 13'h030, 32'h1234_5678);
        do_reset(1'b1);
        access("ld_30_after_rst_store", 1'b0, 2'b00, 13'h030, 32'h0);
        check("ld_30_const", bus.dmem_out, 32'h1234_5678);

        access("st_40_zero", 1'b1, 2'b00, 13'h040, 32'h0);
        access("st_41_mis", 1'b1, 2'b00, 13'h041, 32'h1);
        access("ld_40", 1'b0, 2'b00, 13'h040, 32'h0);
        check("ld_40_const", bus.dmem_out, TRAP ? 32'h0 : 32'h1);
        check("err_after_mis", 32'(bus.dmem_err), TRAP ? 32'h1 : 32'h0);
        idle("err_sticky", 2);
        do_reset(1'b0);
        check("err_cleared", 32'(bus.dmem_err), 32'h0);

        access("st_14", 1'b1, 2'b00, 13'h014, 32'hCAFE_F00D);
        access("b2b_ld_10", 1'b0, 2'b00, 13'h010, 32'h0);
        access("b2b_ld_14", 1'b0, 2'b00, 13'h014, 32'h0);
        check("b2b_ld_14_const", bus.dmem_out, 32'hCAFE_F00D);

        for (int i = 0; i < 16; i++) access("rnd_init", 1'b1, 2'b00, 13'h400 + 13'(4 * i), $urandom);
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 9));
            a = 13'h400 + 13'($urandom_range(0, 63));
            if (r == 0) idle("rnd_idle", int'($urandom_range(1, 3)));
            else access("rnd", 1'($urandom), 2'($urandom), a, $urandom);
        end
        for (int i = 0; i < 16; i++) access("rnd_final", 1'b0, 2'b00, 13'h400 + 13'(4 * i), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
